// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: sequencing state and next-PC source.
// Pure type definitions; no latency.
// No flow control.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        SEQ  = 2'd1,
        ABS  = 2'd2,
        REL  = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_sequencer_branch_lut.sv
// Branch-target table: register array with synchronous write and clear.
// Read is combinational; a write becomes visible after the edge.
// No flow control: writes are always accepted outside reset.
module branch_lut #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    localparam int DEPTH = 1 << LUT_AW;

    logic [PC_W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and start/run/halt sequencer with LUT-resolved branches.
// One-cycle PC update latency; branch/halt decision is combinational on inputs.
// stall holds PC and the retire count for the cycle; no other backpressure.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int LUT_AW   = 4,
    parameter int CNT_W    = 16,
    parameter int START_PC = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic              halt_req,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              branch_cond,
    input  logic              branch_rel,
    input  logic [LUT_AW-1:0] target_idx,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   PC,
    output logic              fetch_valid,
    output logic              Halt,
    output logic [CNT_W-1:0]  inst_count,
    output logic              pc_wrap
);

    state_t          state_q, state_d;
    pc_sel_t         pc_sel;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic            wrap_q;
    logic            restart, retire, wrap_set;
    logic [PC_W-1:0] lut_rdata;

    branch_lut #(
        .PC_W   (PC_W),
        .LUT_AW (LUT_AW)
    ) u_lut (
        .CLK   (CLK),
        .RESET (RESET),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (target_idx),
        .rdata (lut_rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_sel  = HOLD;
        restart = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    restart = 1'b1;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                    retire  = 1'b1;
                end else if (!stall) begin
                    retire = 1'b1;
                    if (branch_en && branch_cond) begin
                        pc_sel = branch_rel ? REL : ABS;
                    end else begin
                        pc_sel = SEQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Relative add is plain modular addition: a two's-complement entry needs no sign handling.
    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            SEQ:     pc_d = pc_q + PC_W'(1);
            ABS:     pc_d = lut_rdata;
            REL:     pc_d = pc_q + lut_rdata;
            default: pc_d = pc_q;
        endcase
        if (restart) begin
            pc_d = PC_W'(START_PC);
        end
    end

    assign wrap_set = (pc_sel == SEQ) && (&pc_q);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= PC_W'(START_PC);
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (restart) begin
                cnt_q  <= '0;
                wrap_q <= 1'b0;
            end else begin
                if (retire && !(&cnt_q)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                if (wrap_set) begin
                    wrap_q <= 1'b1;
                end
            end
        end
    end

    assign PC          = pc_q;
    assign fetch_valid = (state_q == RUN);
    assign Halt        = (state_q == HALTED);
    assign inst_count  = cnt_q;
    assign pc_wrap     = wrap_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised successor to the fixed 10-bit program counter: owns the PC, the start/run/halt sequencing and branch-target resolution for the core. Branch targets come from a writable lookup table addressed by a short instruction field, in absolute or PC-relative mode. Adds stall, a sticky PC-wrap flag and a retired-instruction counter. Sits between the top level (start/halt) and the instruction memory (PC out), driven by decode/ALU branch signals.

Parameters:
PC_W, 10, program counter width in bits
LUT_AW, 4, branch LUT address width; depth = 2**LUT_AW entries of PC_W bits
CNT_W, 16, retired-instruction counter width
START_PC, 0, PC value loaded on start

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
start  input  1  begin or restart execution; honoured only in IDLE or HALTED
halt_req  input  1  current instruction is a halt (valid in RUN)
stall  input  1  hold PC this cycle (valid in RUN)
branch_en  input  1  current instruction is a branch
branch_cond  input  1  branch condition true (e.g. ALU ZERO/EQUAL)
branch_rel  input  1  1 = PC-relative (signed LUT entry), 0 = absolute
target_idx  input  LUT_AW  LUT index from instruction field
lut_we  input  1  LUT write enable
lut_waddr  input  LUT_AW  LUT write address
lut_wdata  input  PC_W  LUT write data
PC  output  PC_W  current fetch address
fetch_valid  output  1  PC holds a live instruction (RUN state)
Halt  output  1  high while HALTED
inst_count  output  CNT_W  retired instructions since last start
pc_wrap  output  1  sticky: sequential PC increment wrapped past all-ones

Behaviour:
- States: IDLE, RUN, HALTED (2-bit encoding). RESET dominates every other input on the edge where it is sampled.
- Reset values: state=IDLE, PC=START_PC, fetch_valid=0, Halt=0, inst_count=0, pc_wrap=0, all LUT entries=0.
- IDLE: PC held. start=1 -> RUN next cycle; PC=START_PC, inst_count=0, pc_wrap=0.
- RUN: fetch_valid=1. Next-PC priority: halt_req > stall > (branch_en & branch_cond) > PC+1.
  - halt_req=1: -> HALTED, PC held, inst_count +1 (halt retires).
  - stall=1 (no halt): PC held, count unchanged.
  - taken branch, absolute: PC <= LUT[target_idx].
  - taken branch, relative: PC <= PC + LUT[target_idx], entry read as signed two's complement, result mod 2**PC_W. Does not set pc_wrap.
  - otherwise PC <= PC+1. PC at all-ones wraps to 0 and sets pc_wrap.
  - inst_count +1 on every non-stalled RUN cycle; saturates at all-ones, never wraps.
  - start ignored in RUN.
- HALTED: Halt=1, fetch_valid=0; PC, inst_count, pc_wrap frozen. start=1 -> RUN next cycle with the IDLE restart actions; Halt drops the same edge.
- Outputs are registered state: PC, Halt, fetch_valid change only on CLK edges. Branch/halt decision is combinational from current-cycle inputs; one-cycle PC update latency.
- LUT: read combinational at target_idx. Write takes effect on the edge, so a same-cycle read of the written entry returns the old value. Writes are accepted in any state except during RESET.
- Inputs halt_req, stall, branch_* are don't-care outside RUN.

Decomposition:
- Package fetch_pkg: state enum (IDLE, RUN, HALTED) and a next-PC select enum (HOLD, SEQ, ABS, REL).
- One sub-module, branch_lut: 2**LUT_AW x PC_W register array, sync write, async read, sync clear on RESET.

Test Plan:
- RESET, then start pulse, 5 free-running cycles -> PC sequence 0,1,2,3,4,5; fetch_valid=1 from cycle after start; inst_count=5.
- Write LUT[3]=0x120; at PC=4 assert branch_en=1, cond=1, rel=0, idx=3 -> next PC=0x120. Same with cond=0 -> PC=5.
- LUT[2]=0x3FE (-2), rel=1, at PC=0x010 -> PC=0x00E. LUT[2]=0x005 at PC=0x3FD -> PC=0x002 with pc_wrap still 0.
- Start at PC=0x3FF with no branch -> PC=0x000, pc_wrap=1 and stays 1 until restart. Stall and halt_req together at PC=7 -> HALTED, PC=7, Halt=1, count incremented.
- In HALTED, pulse start -> Halt=0, PC=0, inst_count=0 next cycle. Assert RESET mid-RUN with a branch pending -> IDLE, PC=0, LUT cleared, branch ignored.
- CNT_W=3: run 10 cycles -> inst_count saturates at 7. Write LUT[1] and read idx=1 in the same cycle -> old value used, new value used next cycle.
